// File: rtl/signed_addsub_seq.sv
// Multi-cycle signed adder/subtractor: WIDTH-bit operation computed CHUNK bits per clock.
// Define SATURATE_EN to clamp the result on signed overflow instead of wrapping.
module signed_addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_eff_p0;
  logic                    carry_p0;
  logic [CNT_W-1:0]        cnt_p0;

  logic signed [WIDTH-1:0] r_p1;
  logic                    cout_p1;
  logic                    ovf_p1;
  logic                    zero_p1;
  logic                    neg_p1;

  int                      base;
  logic [CHUNK:0]          chunk_sum;
  logic signed [WIDTH-1:0] r_next;
  logic signed [WIDTH-1:0] r_final;
  logic                    ovf_next;

`ifdef SATURATE_EN
  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] v,
                                                    input logic o, input logic a_msb);
    if (!o)
      return v;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = CALC;
      CALC:    if (cnt_p0 == LAST) state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Chunk adder: one CHUNK-wide slice per cycle, carry rippled through carry_p0
  always_comb begin
    base      = int'(cnt_p0) * CHUNK;
    chunk_sum = {1'b0, a_p0[base +: CHUNK]} + {1'b0, b_eff_p0[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_p0};
    r_next    = r_p1;
    r_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    ovf_next  = (a_p0[WIDTH-1] == b_eff_p0[WIDTH-1]) && (r_next[WIDTH-1] != a_p0[WIDTH-1]);
`ifdef SATURATE_EN
    r_final   = clamp(r_next, ovf_next, a_p0[WIDTH-1]);
`else
    r_final   = r_next;
`endif
  end

  // Stage p0: operand capture; stage p1: accumulated result and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0     <= '0;
      b_eff_p0 <= '0;
      carry_p0 <= 1'b0;
      cnt_p0   <= '0;
      r_p1     <= '0;
      cout_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
      zero_p1  <= 1'b0;
      neg_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_p0     <= a;
            b_eff_p0 <= sub ? ~b : b;
            carry_p0 <= sub;
            cnt_p0   <= '0;
            r_p1     <= '0;
            cout_p1  <= 1'b0;
            ovf_p1   <= 1'b0;
            zero_p1  <= 1'b0;
            neg_p1   <= 1'b0;
          end
        end
        CALC: begin
          r_p1     <= r_next;
          carry_p0 <= chunk_sum[CHUNK];
          cnt_p0   <= cnt_p0 + CNT_W'(1);
          if (cnt_p0 == LAST) begin
            r_p1    <= r_final;
            cout_p1 <= chunk_sum[CHUNK];
            ovf_p1  <= ovf_next;
            zero_p1 <= (r_final == '0);
            neg_p1  <= r_final[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign r         = r_p1;
  assign cout      = cout_p1;
  assign ovf       = ovf_p1;
  assign zero      = zero_p1;
  assign neg       = neg_p1;

endmodule
